uart_tx_buffered: RTL and testbench

//  Single-clock, FIFO-buffered UART transmitter producing 8-bit LSB-first frames with a configurable

---
 rtl/uart_tx_buffered_if.sv | 19 +
 rtl/uart_tx_buffered.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// Host-side byte handshake for the buffered UART transmitter.
// The host presents tx_data with tx_valid; a byte moves when tx_ready is also high.
interface uart_tx_buffered_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing comes from an internal baud counter, so the whole block runs on txclk alone.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          txclk,
  input  logic                          reset_n,
  uart_tx_buffered_if.slave             bus,
  input  logic                          tx_enable,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    data_reg;

  state_t        state_reg;
  state_t        state_next;
  logic [15:0]   baud_reg;
  logic [15:0]   baud_next;
  logic [2:0]    bit_reg;
  logic [2:0]    bit_next;
  logic          tx_out_reg;
  logic          tx_out_next;

  logic          ready;
  logic          push;
  logic          pop;
  logic          has_data;
  logic          baud_done;
  logic          parity;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign ready        = (count_reg != CW'(FIFO_DEPTH));
  assign bus.tx_ready = ready;
  assign push         = bus.tx_valid && ready;
  assign has_data     = (count_reg != '0);
  assign baud_done    = (baud_reg == BAUD_LAST);
  assign parity       = (^data_reg) ^ PARITY_ODD;

  // Byte storage; no reset so the array can map onto RAM.
  always_ff @(posedge txclk) begin
    if (reset_n && push) begin
      mem[wr_ptr_reg] <= bus.tx_data;
    end
  end

  // Registered read: the popped head byte lands directly in the frame data register.
  always_ff @(posedge txclk) begin
    if (pop) begin
      data_reg <= mem[rd_ptr_reg];
    end
  end

  // FIFO pointers wrap naturally at FIFO_DEPTH; push and pop together keep the count.
  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Frame sequencer state, baud/bit counters and the registered serial line.
  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      tx_out_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      tx_out_reg <= tx_out_next;
    end
  end

  // Next-state logic; the line value is derived from the state being entered so tx_out stays registered.
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg + 16'd1;
    bit_next    = bit_reg;
    pop         = 1'b0;
    tx_out_next = 1'b1;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (has_data && tx_enable) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            bit_next   = '0;
            state_next = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == STOP_LAST) begin
            bit_next = '0;
            // Back-to-back frames: chain straight into the next start bit.
            if (has_data && tx_enable) begin
              pop        = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      default: begin
        baud_next  = '0;
        bit_next   = '0;
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_out_next = 1'b0;
      DATA:    tx_out_next = data_reg[bit_next];
      PARITY:  tx_out_next = parity;
      default: tx_out_next = 1'b1;
    endcase
  end

  assign tx_out     = tx_out_reg;
  assign tx_busy    = (state_reg != IDLE);
  assign tx_empty   = !has_data && (state_reg == IDLE);
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: three instances cover plain, even-parity/2-stop and odd-parity frames.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b, en_c;
  logic       out_a, out_b, out_c;
  logic       busy_a, busy_b, busy_c;
  logic       empty_a, empty_b, empty_c;
  logic [2:0] count_a, count_b, count_c;

  int checks = 0;
  int errors = 0;

  logic samp [0:199];

  logic [7:0] t2_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] t4_bytes [8] = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE7, 8'h18, 8'h99, 8'h66};

  uart_tx_buffered_if bus_a ();
  uart_tx_buffered_if bus_b ();
  uart_tx_buffered_if bus_c ();

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_a (
    .txclk(clk), .reset_n(rst_n), .bus(bus_a), .tx_enable(en_a),
    .tx_out(out_a), .tx_busy(busy_a), .tx_empty(empty_a), .fifo_count(count_a)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_b (
    .txclk(clk), .reset_n(rst_n), .bus(bus_b), .tx_enable(en_b),
    .tx_out(out_b), .tx_busy(busy_b), .tx_empty(empty_b), .fifo_count(count_b)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut_c (
    .txclk(clk), .reset_n(rst_n), .bus(bus_c), .tx_enable(en_c),
    .tx_out(out_c), .tx_busy(busy_c), .tx_empty(empty_c), .fifo_count(count_c)
  );

  initial forever #5 clk = ~clk;

  // Hang guard.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  function automatic logic line(input int sel);
    case (sel)
      0:       return out_a;
      1:       return out_b;
      default: return out_c;
    endcase
  endfunction

  task automatic set_bus(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      0:       begin bus_a.tx_valid = v; bus_a.tx_data = d; end
      1:       begin bus_b.tx_valid = v; bus_b.tx_data = d; end
      default: begin bus_c.tx_valid = v; bus_c.tx_data = d; end
    endcase
  endtask

  // Offer one byte for a single cycle, starting at a falling edge.
  task automatic push(input int sel, input logic [7:0] d);
    $display("push dut%0d data %02h", sel, d);
    set_bus(sel, 1'b1, d);
    @(negedge clk);
    set_bus(sel, 1'b0, 8'h00);
  endtask

  // Record the line once per cycle, beginning with the current falling edge.
  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      samp[i] = line(sel);
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] slice(input int off, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = samp[off + i];
    return v;
  endfunction

  // Each frame bit (LSB = first on the line) repeated for the 4 cycles of a bit.
  function automatic logic [63:0] expand(input logic [15:0] bits, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n * 4; i++) v[i] = bits[i / 4];
    return v;
  endfunction

  function automatic logic [15:0] frame10(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction

  initial begin
    rst_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    set_bus(0, 1'b0, 8'h00);
    set_bus(1, 1'b0, 8'h00);
    set_bus(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx_out", out_a, 1);
    check("rst_ready", bus_a.tx_ready, 1);
    check("rst_busy", busy_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_count", count_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: 0xA5, 4 clocks per bit, 40-cycle frame
    push(0, 8'hA5);
    check("t1_pre_line", out_a, 1);
    check("t1_pre_count", count_a, 1);
    @(negedge clk);
    check("t1_start_latency", out_a, 0);
    capture(0, 40);
    check("t1_frame", slice(0, 40), expand(16'b1101001010, 10));
    check("t1_empty", empty_a, 1);
    check("t1_busy", busy_a, 0);
    check("t1_idle_line", out_a, 1);

    // T2: disabled, 5 back-to-back offers, only 4 fit
    en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_bus(0, 1'b1, t2_bytes[k]);
      @(negedge clk);
    end
    set_bus(0, 1'b0, 8'h00);
    check("t2_count_full", count_a, 4);
    check("t2_ready_full", bus_a.tx_ready, 0);
    check("t2_busy_disabled", busy_a, 0);
    check("t2_line_disabled", out_a, 1);
    en_a = 1'b1;
    @(negedge clk);
    capture(0, 160);
    for (int f = 0; f < 4; f++)
      check($sformatf("t2_frame%0d", f), slice(f * 40, 40), expand(frame10(t2_bytes[f]), 10));
    check("t2_empty_after", empty_a, 1);
    check("t2_count_after", count_a, 0);

    // T3: even parity + 2 stop bits, odd parity + 1 stop bit
    push(1, 8'hA5);
    @(negedge clk);
    capture(1, 48);
    check("t3_even_a5", slice(0, 48), expand(16'b110101001010, 12));
    check("t3_even_a5_done", busy_b, 0);
    push(1, 8'h01);
    @(negedge clk);
    capture(1, 48);
    check("t3_even_01", slice(0, 48), expand(16'b111000000010, 12));
    check("t3_even_01_done", busy_b, 0);
    push(2, 8'hA5);
    @(negedge clk);
    capture(2, 44);
    check("t3_odd_a5", slice(0, 44), expand(16'b11101001010, 11));
    check("t3_odd_a5_done", busy_c, 0);

    // T4: valid held high against a full FIFO while frames drain
    begin
      int max_count;
      max_count = 0;
      fork
        begin
          int idx;
          int guard;
          logic acc;
          idx = 0;
          guard = 0;
          while (idx < 8 && guard < 2000) begin
            set_bus(0, 1'b1, t4_bytes[idx]);
            acc = bus_a.tx_ready;
            @(negedge clk);
            guard++;
            if (int'(count_a) > max_count) max_count = int'(count_a);
            if (acc) idx++;
          end
          set_bus(0, 1'b0, 8'h00);
          if (idx < 8) check("t4_host_timeout", idx, 8);
        end
        begin
          int w;
          for (int f = 0; f < 8; f++) begin
            w = 0;
            while (out_a !== 1'b0 && w < 300) begin
              @(negedge clk);
              w++;
            end
            if (w >= 300) begin
              check("t4_rx_timeout", f, 8);
              break;
            end
            capture(0, 40);
            $display("frame dut0 index %0d", f);
            check($sformatf("t4_frame%0d", f), slice(0, 40), expand(frame10(t4_bytes[f]), 10));
          end
        end
      join
      check("t4_max_count", max_count, 4);
      check("t4_empty_after", empty_a, 1);
    end

    // T5: reset during the data bits
    set_bus(0, 1'b1, 8'h3C);
    @(negedge clk);
    set_bus(0, 1'b1, 8'h5A);
    @(negedge clk);
    set_bus(0, 1'b0, 8'h00);
    check("t5_started", out_a, 0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_line", out_a, 1);
    check("t5_rst_count", count_a, 0);
    check("t5_rst_empty", empty_a, 1);
    check("t5_rst_busy", busy_a, 0);
    rst_n = 1'b1;
    begin
      int zeros;
      zeros = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (out_a !== 1'b1) zeros++;
      end
      check("t5_no_residual", zeros, 0);
      check("t5_count_after", count_a, 0);
    end

    // T6: enable dropped during bit 3 with two bytes queued
    set_bus(0, 1'b1, 8'hB1);
    @(negedge clk);
    set_bus(0, 1'b1, 8'hB2);
    @(negedge clk);
    set_bus(0, 1'b1, 8'hB3);
    @(negedge clk);
    set_bus(0, 1'b0, 8'h00);
    repeat (16) @(negedge clk);
    en_a = 1'b0;
    check("t6_bit3_busy", busy_a, 1);
    repeat (23) @(negedge clk);
    check("t6_idle_busy", busy_a, 0);
    check("t6_idle_count", count_a, 2);
    check("t6_idle_line", out_a, 1);
    repeat (5) @(negedge clk);
    check("t6_hold_count", count_a, 2);
    check("t6_hold_line", out_a, 1);
    en_a = 1'b1;
    @(negedge clk);
    check("t6_restart_line", out_a, 0);
    check("t6_restart_count", count_a, 1);
    capture(0, 80);
    check("t6_frame_b2", slice(0, 40), expand(frame10(8'hB2), 10));
    check("t6_frame_b3", slice(40, 40), expand(frame10(8'hB3), 10));
    check("t6_empty_after", empty_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
